// File: rtl/rsp_buff.sv
// rtl/rsp_buff.sv - response FIFO with AXI read-side pop, status read and empty-read timeout
module rsp_buff #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter int         DEPTH      = 4,
    parameter int         TIMEOUT    = 16,
    parameter logic [1:0] RSP_REGION = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_rsp_buff_in_vld,
    input  logic [DATA_WIDTH-1:0] ctrl_rsp_buff_in_data,
    output logic                  rsp_buff_ctrl_rdy,
    input  logic                  axi_rd_vld,
    input  logic [ADDR_WIDTH-1:0] axi_rd_addr,
    input  logic [1:0]            axi_rd_region,
    output logic                  fifo_rd_done,
    output logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  rd_qual;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_err;

    // Only bit 2 of the address selects status vs data; the rest is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_rd_addr[ADDR_WIDTH-1:3], axi_rd_addr[1:0]};

    // Occupancy flags come straight from the registered pointers, so a pop
    // in the same cycle cannot open a slot for a push while full.
    assign full              = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty             = (wr_ptr == rd_ptr);
    assign count             = wr_ptr - rd_ptr;
    assign rsp_buff_ctrl_rdy = ~full;
    assign push              = ctrl_rsp_buff_in_vld & ~full;
    assign head              = mem[rd_ptr[AW-1:0]];
    assign rd_qual           = axi_rd_vld && (axi_rd_region == RSP_REGION) && (state == ST_IDLE);
    assign fifo_rd_done      = (state == ST_RESP);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= ctrl_rsp_buff_in_data;
        end
    end

    // Read/write pointers with wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Read FSM: decide pop, wait, timeout and the response word to present.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_qual) begin
                    if (axi_rd_addr[2]) begin
                        state_nxt = ST_RESP;
                        load      = 1'b1;
                        load_data = DATA_WIDTH'(count);
                    end else if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_RESP;
                        load      = 1'b1;
                        load_data = head;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_RESP;
                    load      = 1'b1;
                    load_data = head;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_RESP;
                    load      = 1'b1;
                    load_err  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Response data/error are captured on entry to RESP and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_data <= '0;
            fifo_rd_err  <= 1'b0;
        end else if (load) begin
            fifo_rd_data <= load_data;
            fifo_rd_err  <= load_err;
        end
    end

endmodule
